// File: rtl/sos_cascade_sched_if.sv
// Handshake, config and shared-multiplier bundle for the SOS cascade scheduler.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the sample path; the multiplier path has none.
interface sos_cascade_sched_if #(
    parameter int DW = 24,
    parameter int AW = 6
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_err;
    logic          clr_state;
    logic          busy;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_vin;
    logic [DW-1:0] mul_p;
    logic          mul_vout;

    // master: the environment (sample source, config host, multiplier)
    modport master (
        output in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, clr_state, mul_p, mul_vout,
        input  in_ready, out_valid, out_data, cfg_err, busy, mul_a, mul_b, mul_vin
    );

    modport slave (
        input  in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, clr_state, mul_p, mul_vout,
        output in_ready, out_valid, out_data, cfg_err, busy, mul_a, mul_b, mul_vin
    );
endinterface

// File: rtl/sos_cascade_sched.sv
// Cascade of NUM_SEC biquads time-multiplexed onto one external pipelined multiplier.
// Latency: out_valid NUM_SEC*(L+7)+1 cycles after the accepting edge (L = multiplier latency).
// Backpressure: in_ready low for the whole sample; cfg writes while busy are rejected with cfg_err.
module sos_cascade_sched #(
    parameter int NUM_SEC = 2,
    parameter int DW      = 24,
    parameter int AW      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    sos_cascade_sched_if.slave bus
);

    localparam int NC  = 5 * NUM_SEC;
    localparam int CW  = $clog2(NC);
    localparam int SW  = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
    localparam int ACW = DW + 3;

    localparam logic signed [ACW-1:0] SAT_MAX = {4'b0000, {(DW-1){1'b1}}};
    localparam logic signed [ACW-1:0] SAT_MIN = {4'b1111, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WB, DONE} state_t;

    state_t                 state;
    logic [SW-1:0]          sec;
    logic [CW-1:0]          cbase;
    logic [2:0]             kis;
    logic [2:0]             rcnt;
    logic signed [DW-1:0]   xcur;
    logic signed [ACW-1:0]  acc;

    logic signed [DW-1:0]   coef [NC];
    logic signed [DW-1:0]   x1   [NUM_SEC];
    logic signed [DW-1:0]   x2   [NUM_SEC];
    logic signed [DW-1:0]   y1   [NUM_SEC];
    logic signed [DW-1:0]   y2   [NUM_SEC];

    logic [CW-1:0]          cidx;
    logic signed [DW-1:0]   op_b;
    logic signed [ACW-1:0]  p_ext;
    logic signed [ACW-1:0]  acc_nxt;
    logic signed [DW-1:0]   y_sat;
    logic                   cfg_bad;
    logic                   last_sec;
    logic                   ret_ok;
    logic                   drained;

    assign cidx     = cbase + CW'(kis);
    assign p_ext    = {{3{bus.mul_p[DW-1]}}, bus.mul_p};
    // feed-forward taps add, feedback taps subtract; the return count picks which
    assign acc_nxt  = (rcnt < 3'd3) ? (acc + p_ext) : (acc - p_ext);
    assign cfg_bad  = (bus.cfg_addr >= AW'(NC));
    assign last_sec = (sec == SW'(NUM_SEC - 1));
    assign ret_ok   = bus.mul_vout && ((state == ISSUE) || (state == DRAIN));
    assign drained  = (rcnt == 3'd5) || (bus.mul_vout && (rcnt == 3'd4));

    always_comb begin
        op_b = xcur;
        case (kis)
            3'd0:    op_b = xcur;
            3'd1:    op_b = x1[sec];
            3'd2:    op_b = x2[sec];
            3'd3:    op_b = y1[sec];
            default: op_b = y2[sec];
        endcase
    end

    always_comb begin
        y_sat = acc[DW-1:0];
        if (acc > SAT_MAX) begin
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sec           <= '0;
            cbase         <= '0;
            kis           <= '0;
            rcnt          <= '0;
            xcur          <= '0;
            acc           <= '0;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.cfg_err   <= 1'b0;
            bus.mul_vin   <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            for (int i = 0; i < NC; i++) begin
                coef[i] <= '0;
            end
            for (int s = 0; s < NUM_SEC; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            bus.cfg_err   <= 1'b0;

            if (bus.cfg_we) begin
                if ((state != IDLE) || cfg_bad) begin
                    bus.cfg_err <= 1'b1;
                end else begin
                    coef[bus.cfg_addr[CW-1:0]] <= bus.cfg_wdata;
                end
            end

            // products may land while the tail of ISSUE is still running
            if (ret_ok) begin
                acc  <= acc_nxt;
                rcnt <= rcnt + 3'd1;
            end

            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    bus.busy     <= 1'b0;
                    bus.mul_vin  <= 1'b0;
                    if (bus.clr_state) begin
                        for (int s = 0; s < NUM_SEC; s++) begin
                            x1[s] <= '0;
                            x2[s] <= '0;
                            y1[s] <= '0;
                            y2[s] <= '0;
                        end
                    end
                    if (bus.in_valid) begin
                        xcur         <= bus.in_data;
                        sec          <= '0;
                        cbase        <= '0;
                        kis          <= '0;
                        state        <= ISSUE;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end

                ISSUE: begin
                    bus.mul_vin <= 1'b1;
                    bus.mul_a   <= coef[cidx];
                    bus.mul_b   <= op_b;
                    kis         <= kis + 3'd1;
                    if (kis == 3'd4) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    bus.mul_vin <= 1'b0;
                    if (drained) begin
                        state <= WB;
                    end
                end

                WB: begin
                    acc     <= '0;
                    rcnt    <= '0;
                    kis     <= '0;
                    x2[sec] <= x1[sec];
                    x1[sec] <= xcur;
                    y2[sec] <= y1[sec];
                    y1[sec] <= y_sat;
                    xcur    <= y_sat;
                    if (last_sec) begin
                        state <= DONE;
                    end else begin
                        sec   <= sec + SW'(1);
                        cbase <= cbase + CW'(5);
                        state <= ISSUE;
                    end
                end

                DONE: begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= xcur;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sos_cascade_sched.sv
// Bench for sos_cascade_sched: Q2.22 multiplier model (L=2), direct-form-I reference model,
// expected outputs queued at accept and compared when out_valid fires.
module tb_sos_cascade_sched;

    localparam int DW  = 24;
    localparam int AW  = 6;
    localparam int NS  = 2;
    localparam int LAT = NS * (2 + 7) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sos_cascade_sched_if #(.DW(DW), .AW(AW)) ifc ();

    sos_cascade_sched #(.NUM_SEC(NS), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int vin_cnt = 0;
    logic prev_ov = 1'b0;
    logic [23:0] last_out = '0;
    logic [23:0] q[$];

    int mc [10];
    int mx1[NS], mx2[NS], my1[NS], my2[NS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [23:0] v);
        return int'({{8{v[23]}}, v});
    endfunction

    function automatic int mulq(input int a, input int b);
        longint p;
        logic [23:0] t;
        p = longint'(a) * longint'(b);
        p = p >>> 22;
        t = p[23:0];
        return sx(t);
    endfunction

    function automatic void model_clear_state();
        for (int s = 0; s < NS; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    function automatic int model_step(input int x);
        int xs;
        longint a;
        int y;
        xs = x;
        for (int s = 0; s < NS; s++) begin
            a = longint'(mulq(mc[5*s], xs)) + longint'(mulq(mc[5*s+1], mx1[s]))
              + longint'(mulq(mc[5*s+2], mx2[s])) - longint'(mulq(mc[5*s+3], my1[s]))
              - longint'(mulq(mc[5*s+4], my2[s]));
            if (a > 64'sd8388607) y = 8388607;
            else if (a < -64'sd8388608) y = -8388608;
            else y = int'(a);
            mx2[s] = mx1[s]; mx1[s] = xs;
            my2[s] = my1[s]; my1[s] = y;
            xs = y;
        end
        return xs;
    endfunction

    // Q2.22 multiplier, two pipeline registers, not flushed by reset
    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [23:0] s1_p = '0, s2_p = '0;
    always @(posedge clk) begin
        s1_v <= ifc.mul_vin;
        s1_p <= 24'(mulq(sx(ifc.mul_a), sx(ifc.mul_b)));
        s2_v <= s1_v;
        s2_p <= s1_p;
    end
    assign ifc.mul_vout = s2_v;
    assign ifc.mul_p    = s2_p;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                vin_cnt = 0;
                prev_ov = 1'b0;
            end else begin
                if (prev_ov) chk("out_valid_width", ifc.out_valid, 1'b0);
                if (ifc.mul_vin) vin_cnt++;
                if (ifc.out_valid) begin
                    if (q.size() == 0) begin
                        chk("out_valid_unexpected", ifc.out_valid, 1'b0);
                    end else begin
                        chk("out_data", ifc.out_data, q.pop_front());
                        chk("latency", cyc - acc_cyc, LAT);
                        chk("mul_ops", vin_cnt, 5 * NS);
                    end
                    vin_cnt = 0;
                    last_out = ifc.out_data;
                end
                prev_ov = ifc.out_valid;
            end
        end
    end

    task automatic send(input logic [23:0] x, input bit clr);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) begin
            chk("in_ready_timeout", ifc.in_ready, 1'b1);
        end else begin
            if (clr) model_clear_state();
            q.push_back(24'(model_step(sx(x))));
            ifc.in_valid  = 1'b1;
            ifc.in_data   = x;
            ifc.clr_state = clr;
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            @(negedge clk);
            ifc.in_valid  = 1'b0;
            ifc.clr_state = 1'b0;
        end
    endtask

    task automatic cfg_wr(input int addr, input logic [23:0] d, input logic exp_err);
        @(negedge clk);
        ifc.cfg_we    = 1'b1;
        ifc.cfg_addr  = AW'(addr);
        ifc.cfg_wdata = d;
        @(posedge clk);
        #1;
        chk("cfg_err", ifc.cfg_err, exp_err);
        @(negedge clk);
        ifc.cfg_we = 1'b0;
        if (!exp_err) mc[addr] = sx(d);
        @(posedge clk);
        #1;
        chk("cfg_err_width", ifc.cfg_err, 1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        chk("drain_timeout", q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    logic [23:0] imp_exp [4];
    logic [23:0] v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.cfg_we = 1'b0;
        ifc.cfg_addr = '0; ifc.cfg_wdata = '0; ifc.clr_state = 1'b0;
        for (int i = 0; i < 10; i++) mc[i] = 0;
        model_clear_state();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ifc.in_ready, 1'b0);
        chk("rst_busy", ifc.busy, 1'b0);
        chk("rst_out_valid", ifc.out_valid, 1'b0);
        chk("rst_out_data", ifc.out_data, 0);
        chk("rst_cfg_err", ifc.cfg_err, 1'b0);
        chk("rst_mul_vin", ifc.mul_vin, 1'b0);
        chk("rst_mul_a", ifc.mul_a, 0);
        chk("rst_mul_b", ifc.mul_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", ifc.in_ready, 1'b1);

        // unity gain in both sections
        cfg_wr(0, 24'h400000, 1'b0);
        cfg_wr(5, 24'h400000, 1'b0);
        send(24'h123456, 1'b0);
        wait_drain();
        chk("passthru", last_out, 24'h123456);

        // rejected writes: while busy, and address past the last coefficient
        send(24'h0ABCDE, 1'b0);
        chk("busy_during_sample", ifc.busy, 1'b1);
        cfg_wr(0, 24'h200000, 1'b1);
        wait_drain();
        chk("busy_write_ignored", last_out, 24'h0ABCDE);
        cfg_wr(10, 24'h111111, 1'b1);
        send(24'h654321, 1'b0);
        wait_drain();
        chk("oob_write_ignored", last_out, 24'h654321);

        // first-order IIR in section 0 (a1 = -0.5), section 1 passes through
        cfg_wr(3, 24'hE00000, 1'b0);
        imp_exp[0] = 24'h100000; imp_exp[1] = 24'h080000;
        imp_exp[2] = 24'h040000; imp_exp[3] = 24'h020000;
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 24'h100000 : 24'h000000;
            send(v, i == 0);
            wait_drain();
            chk("impulse", last_out, imp_exp[i]);
        end

        // clear together with a new sample after nonzero history
        send(24'h100000, 1'b1);
        wait_drain();
        chk("clr_with_valid", last_out, 24'h100000);

        // saturation: b0=b1=b2=1.0, no feedback
        cfg_wr(1, 24'h400000, 1'b0);
        cfg_wr(2, 24'h400000, 1'b0);
        cfg_wr(3, 24'h000000, 1'b0);
        for (int i = 0; i < 3; i++) send(24'h7FFFFF, i == 0);
        wait_drain();
        chk("sat_pos", last_out, 24'h7FFFFF);
        for (int i = 0; i < 3; i++) send(24'h800000, i == 0);
        wait_drain();
        chk("sat_neg", last_out, 24'h800000);

        // random coefficients in [-0.5, 0.5) and random samples, back to back
        for (int i = 0; i < 10; i++) begin
            v = 24'(int'($urandom_range(0, 32'h3FFFFF)) - 32'sh200000);
            cfg_wr(i, v, 1'b0);
        end
        for (int i = 0; i < 8; i++) send(24'($urandom), i == 0);
        wait_drain();

        // reset in the middle of DRAIN of section 0
        send(24'h100000, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", ifc.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        q.delete();
        for (int i = 0; i < 10; i++) mc[i] = 0;
        model_clear_state();
        chk("arst_busy", ifc.busy, 1'b0);
        chk("arst_mul_vin", ifc.mul_vin, 1'b0);
        chk("arst_out_data", ifc.out_data, 0);
        chk("arst_in_ready", ifc.in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        send(24'h123456, 1'b0);
        wait_drain();
        chk("coef_cleared", last_out, 24'h000000);
        cfg_wr(0, 24'h400000, 1'b0);
        cfg_wr(5, 24'h400000, 1'b0);
        cfg_wr(3, 24'hE00000, 1'b0);
        send(24'h100000, 1'b0);
        wait_drain();
        chk("fresh_impulse0", last_out, 24'h100000);
        send(24'h000000, 1'b0);
        wait_drain();
        chk("fresh_impulse1", last_out, 24'h080000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
